// File: rtl/ahbl_sram_slave.sv
// ---------------------------------------------------------------------------
// ahbl_sram_slave
//   AHB-Lite responder fronting a word-organised on-chip SRAM.
//   Captures the address phase when the global hready is high. It inserts
//   WAIT wait states per valid transfer. It writes byte/halfword/word data
//   through lane strobes. Illegal transfers (oversized or misaligned) get a
//   two-cycle ERROR response and never touch memory.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   hsel       slave select from the address decoder
//   haddr      byte address; only haddr[AW-1:0] is used (upper bits alias)
//   htrans     IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   hwrite     1 = write
//   hsize      0 = byte, 1 = halfword, 2 = word
//   hburst     accepted, ignored
//   hwdata     write data, valid in the data phase
//   hready     global bus ready from the interconnect
//   hreadyout  this slave's ready, to the response mux
//   hresp      0 = OKAY, 1 = ERROR
//   hrdata     read data; full word during a legal read data phase, else 0
// ---------------------------------------------------------------------------
module ahbl_sram_slave #(
  parameter int AW   = 10,
  parameter int DW   = 32,
  parameter int WAIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsel,
  input  logic [31:0]   haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [DW-1:0] hwdata,
  input  logic          hready,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata
);

  localparam int DEPTH = 2 ** (AW - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    ERR1   = 2'd2,
    ERR2   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;

  // Data-phase context captured at the end of the address phase.
  logic          dp_valid;   // legal, selected NONSEQ/SEQ transfer
  logic [AW-1:0] dp_addr;
  logic          dp_write;
  logic [2:0]    dp_size;

  logic [DW-1:0] mem [DEPTH];

  logic          req;
  logic          legal;
  logic          accept;
  logic          wr_en;
  logic [3:0]    strb;

  // The upper address bits and hburst are intentionally ignored.
  logic          unused_bits;
  assign unused_bits = ^{haddr[31:AW], hburst};

  assign req   = hsel & htrans[1];
  assign legal = (hsize <= 3'd2)
              && !((hsize == 3'd1) && haddr[0])
              && !((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  // Only IDLE and ERR2 can start a new transfer; in the other states this
  // slave holds hreadyout low, so hready would be low anyway.
  assign accept = hready && ((state == IDLE) || (state == ERR2));

  // The data phase ends at the edge where this slave is ready in IDLE.
  assign wr_en = dp_valid && dp_write && (state == IDLE) && hready;

  always_comb begin
    unique case (dp_size)
      3'd0:    strb = 4'b0001 << dp_addr[1:0];
      3'd1:    strb = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dp_valid <= 1'b0;
      dp_addr  <= '0;
      dp_write <= 1'b0;
      dp_size  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        dp_valid <= req && legal;
        dp_addr  <= haddr[AW-1:0];
        dp_write <= hwrite;
        dp_size  <= hsize;
      end
    end
  end

  // NOTE: the SRAM array has no reset; it maps onto a RAM macro and its
  // contents are undefined after power-up.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && strb[i]) begin
        mem[dp_addr[AW-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state)
      IDLE, ERR2: begin
        hresp   = (state == ERR2);
        state_n = IDLE;
        if (accept && req) begin
          if (!legal) begin
            state_n = ERR1;
          end else if (WAIT > 0) begin
            state_n = WAITST;
            cnt_n   = 4'(WAIT);
          end
        end
      end
      WAITST: begin
        hreadyout = 1'b0;
        cnt_n     = cnt - 4'd1;
        if (cnt == 4'd1) state_n = IDLE;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_n   = ERR2;
      end
      default: state_n = IDLE;
    endcase
  end

  // The write of a preceding transfer commits at the edge that starts this
  // read data phase, so a back-to-back read sees the new word.
  assign hrdata = ((state == IDLE) && dp_valid && !dp_write)
                ? mem[dp_addr[AW-1:2]] : '0;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahbl_sram_slave
//   Directed bench for ahbl_sram_slave. Three instances share the address and
//   data buses: index 0 has WAIT=0, index 1 has WAIT=3 and index 2 has WAIT=5.
//   Each instance has its own hsel. Each instance sees its own hreadyout as
//   the global hready, gated by "stall" to mimic another slave holding the
//   bus.
// ---------------------------------------------------------------------------
module tb_ahbl_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        stall;
  logic [2:0]  hready;
  logic [2:0]  ro;
  logic [2:0]  rsp;
  logic [31:0] rd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign hready = ro & ~{3{stall}};

  ahbl_sram_slave #(.AW(10), .DW(32), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready[0]), .hreadyout(ro[0]), .hresp(rsp[0]), .hrdata(rd[0]));

  ahbl_sram_slave #(.AW(10), .DW(32), .WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready[1]), .hreadyout(ro[1]), .hresp(rsp[1]), .hrdata(rd[1]));

  ahbl_sram_slave #(.AW(10), .DW(32), .WAIT(5)) dut5 (
    .clk(clk), .rst(rst), .hsel(hsel[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready(hready[2]), .hreadyout(ro[2]), .hresp(rsp[2]), .hrdata(rd[2]));

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    hsel   = '0;
    htrans = 2'd0;
    hwrite = 1'b0;
    hsize  = 3'd0;
  endtask

  // One non-pipelined transfer on instance s. Called and returns at #1 after
  // a rising edge. Reports the data-phase wait count, the first data-phase
  // cycle's ready/resp and the final cycle's resp and read data.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rdat, output int waits,
                      output logic first_rdy, output logic first_resp,
                      output logic last_resp);
    int n;
    hsel    = '0;
    hsel[s] = 1'b1;
    htrans  = 2'd2;
    haddr   = a;
    hwrite  = wr;
    hsize   = sz;
    n = 0;
    @(negedge clk);
    while (!hready[s] && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("addr_phase_timeout", 32'(n < 64), 32'd1);
    @(posedge clk); #1;
    go_idle();
    hwdata = wd;
    waits  = 0;
    @(negedge clk);
    first_rdy  = ro[s];
    first_resp = rsp[s];
    while (!ro[s] && waits < 64) begin
      waits++;
      @(negedge clk);
    end
    rdat      = rd[s];
    last_resp = rsp[s];
    @(posedge clk); #1;
  endtask

  logic [31:0] rdat;
  int          waits;
  int          lows;
  logic        frdy, fresp, lresp;

  initial begin
    rst    = 1'b1;
    stall  = 1'b0;
    haddr  = '0;
    hwdata = '0;
    hburst = '0;
    go_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of all three instances.
    @(negedge clk);
    check("rst_hreadyout", {29'd0, ro}, 32'h7);
    check("rst_hresp", {29'd0, rsp}, 32'h0);
    check("rst_hrdata0", rd[0], 32'h0);
    check("rst_hrdata5", rd[2], 32'h0);
    @(posedge clk); #1;

    // WAIT=0: pipelined write then read of 0x010.
    hsel[0] = 1'b1; htrans = 2'd2; haddr = 32'h010; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'hDEADBEEF;
    hwrite = 1'b0;
    @(negedge clk);
    check("w0_wr_ready", {31'd0, ro[0]}, 32'd1);
    check("w0_wr_resp", {31'd0, rsp[0]}, 32'd0);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    check("w0_raw_data", rd[0], 32'hDEADBEEF);
    check("w0_rd_ready", {31'd0, ro[0]}, 32'd1);
    check("w0_rd_resp", {31'd0, rsp[0]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("w0_idle_hrdata", rd[0], 32'h0);
    @(posedge clk); #1;

    // Byte lanes.
    xfer(0, 1'b1, 32'h020, 3'd2, 32'h00000000, rdat, waits, frdy, fresp, lresp);
    xfer(0, 1'b1, 32'h021, 3'd0, 32'h0000AA00, rdat, waits, frdy, fresp, lresp);
    xfer(0, 1'b1, 32'h022, 3'd1, 32'h55660000, rdat, waits, frdy, fresp, lresp);
    check("lane_wr_waits", 32'(waits), 32'd0);
    xfer(0, 1'b0, 32'h020, 3'd2, 32'h0, rdat, waits, frdy, fresp, lresp);
    check("lane_rd_data", rdat, 32'h5566AA00);

    // Misaligned word write: two-cycle ERROR, memory untouched.
    xfer(0, 1'b1, 32'h012, 3'd2, 32'h12345678, rdat, waits, frdy, fresp, lresp);
    check("err_first_ready", {31'd0, frdy}, 32'd0);
    check("err_first_resp", {31'd0, fresp}, 32'd1);
    check("err_last_resp", {31'd0, lresp}, 32'd1);
    check("err_len", 32'(waits), 32'd1);
    xfer(0, 1'b0, 32'h010, 3'd2, 32'h0, rdat, waits, frdy, fresp, lresp);
    check("err_no_write", rdat, 32'hDEADBEEF);
    check("err_after_resp", {31'd0, lresp}, 32'd0);
    // Oversized hsize is also illegal.
    xfer(0, 1'b1, 32'h020, 3'd3, 32'hFFFFFFFF, rdat, waits, frdy, fresp, lresp);
    check("size3_resp", {31'd0, fresp}, 32'd1);

    // No-capture cycles: IDLE, BUSY, hsel=0, and hready held low by another slave.
    hwdata = 32'hFFFFFFFF;
    hsel[0] = 1'b1; htrans = 2'd0; haddr = 32'h020; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'd1;
    @(negedge clk);
    check("idle_ready", {31'd0, ro[0]}, 32'd1);
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans = 2'd2;
    @(negedge clk);
    check("busy_resp", {31'd0, rsp[0]}, 32'd0);
    @(posedge clk); #1;
    hsel[0] = 1'b1; stall = 1'b1;
    @(negedge clk);
    check("nosel_ready", {31'd0, ro[0]}, 32'd1);
    @(posedge clk); #1;
    go_idle();
    stall = 1'b0;
    @(negedge clk);
    check("stall_ready", {31'd0, ro[0]}, 32'd1);
    check("stall_resp", {31'd0, rsp[0]}, 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h020, 3'd2, 32'h0, rdat, waits, frdy, fresp, lresp);
    check("nocap_mem", rdat, 32'h5566AA00);

    // Address alias: 0x404 maps to 0x004.
    xfer(0, 1'b1, 32'h404, 3'd2, 32'h0BADCAFE, rdat, waits, frdy, fresp, lresp);
    xfer(0, 1'b0, 32'h004, 3'd2, 32'h0, rdat, waits, frdy, fresp, lresp);
    check("alias_data", rdat, 32'h0BADCAFE);

    // WAIT=3: setup writes, then pipelined reads with the next address held.
    xfer(1, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF, rdat, waits, frdy, fresp, lresp);
    check("w3_wr_waits", 32'(waits), 32'd3);
    xfer(1, 1'b1, 32'h014, 3'd2, 32'h01400014, rdat, waits, frdy, fresp, lresp);
    hsel[1] = 1'b1; htrans = 2'd2; haddr = 32'h010; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk); #1;
    haddr = 32'h014;
    lows = 0;
    @(negedge clk);
    while (!ro[1] && lows < 64) begin
      lows++;
      @(negedge clk);
    end
    check("w3_rd0_waits", 32'(lows), 32'd3);
    check("w3_rd0_data", rd[1], 32'hDEADBEEF);
    check("w3_rd0_resp", {31'd0, rsp[1]}, 32'd0);
    @(posedge clk); #1;
    go_idle();
    lows = 0;
    @(negedge clk);
    while (!ro[1] && lows < 64) begin
      lows++;
      @(negedge clk);
    end
    check("w3_rd1_waits", 32'(lows), 32'd3);
    check("w3_rd1_data", rd[1], 32'h01400014);
    @(posedge clk); #1;

    // WAIT=5: reset during WAITST discards the pending write.
    xfer(2, 1'b1, 32'h030, 3'd2, 32'h11111111, rdat, waits, frdy, fresp, lresp);
    check("w5_wr_waits", 32'(waits), 32'd5);
    hsel[2] = 1'b1; htrans = 2'd2; haddr = 32'h030; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    go_idle();
    hwdata = 32'hCAFEF00D;
    @(negedge clk);
    check("w5_in_wait", {31'd0, ro[2]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'd0, ro[2]}, 32'd1);
    check("midrst_resp", {31'd0, rsp[2]}, 32'd0);
    check("midrst_hrdata", rd[2], 32'h0);
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'h030, 3'd2, 32'h0, rdat, waits, frdy, fresp, lresp);
    check("midrst_no_write", rdat, 32'h11111111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
